// File: rtl/issue_stage.sv
// -----------------------------------------------------------------------------
// issue_stage
//   Decode-to-execute issue stage in front of the 32x32 register file read ports.
//   Accepts decoded instructions over a valid/ready handshake. Reads operands
//   from the register file and bypasses the value being written back this
//   cycle. A 32-entry scoreboard tracks registers that are still in flight and
//   stalls on RAW and WAW hazards. The issued instruction is registered into a
//   one-entry output slot that feeds execute.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   dec_valid / dec_ready          decode handshake
//   dec_rs1/_en, dec_rs2/_en       source register indices and use flags
//   dec_rd, dec_rd_we              destination register index and write flag
//   dec_pc, dec_ctrl               PC and opaque control bundle (passed through)
//   rf_re1/2, rf_raddr1/2          register file read enables and addresses
//   rf_rdata1/2                    register file read data (combinational)
//   wb_valid, wb_rd, wb_data       writeback port (also drives the regfile write)
//   flush                          kill the output slot, block acceptance
//   ex_valid / ex_ready            output slot handshake
//   ex_op1/2, ex_rd, ex_rd_we,
//   ex_pc, ex_ctrl                 issued instruction contents
//   stall_cnt                      saturating count of stalled decode cycles
// -----------------------------------------------------------------------------
module issue_stage #(
  parameter int XLEN   = 32,
  parameter int PC_W   = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  // decode side
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [4:0]        dec_rs1,
  input  logic              dec_rs1_en,
  input  logic [4:0]        dec_rs2,
  input  logic              dec_rs2_en,
  input  logic [4:0]        dec_rd,
  input  logic              dec_rd_we,
  input  logic [PC_W-1:0]   dec_pc,
  input  logic [CTRL_W-1:0] dec_ctrl,
  // register file read ports
  output logic              rf_re1,
  output logic [4:0]        rf_raddr1,
  input  logic [XLEN-1:0]   rf_rdata1,
  output logic              rf_re2,
  output logic [4:0]        rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata2,
  // writeback
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  // pipeline control
  input  logic              flush,
  // execute side
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [4:0]        ex_rd,
  output logic              ex_rd_we,
  output logic [PC_W-1:0]   ex_pc,
  output logic [CTRL_W-1:0] ex_ctrl,
  // statistics
  output logic [31:0]       stall_cnt
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]       pending_q,  pending_d;
  logic              ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]   ex_op1_q,   ex_op1_d;
  logic [XLEN-1:0]   ex_op2_q,   ex_op2_d;
  logic [4:0]        ex_rd_q,    ex_rd_d;
  logic              ex_rd_we_q, ex_rd_we_d;
  logic [PC_W-1:0]   ex_pc_q,    ex_pc_d;
  logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [31:0]     clr_mask, set_mask, kill_mask, pend_eff;
  logic            hazard, accept;
  logic [XLEN-1:0] op1, op2;

  function automatic logic [31:0] onehot(input logic [4:0] idx);
    onehot = 32'd1 << idx;
  endfunction

  // Reads bypass the writeback value: the regfile only updates on the edge,
  // so its read data for wb_rd is still the old value in this cycle.
  function automatic logic [XLEN-1:0] resolve(input logic            en,
                                              input logic [4:0]      idx,
                                              input logic [XLEN-1:0] rdata,
                                              input logic            wv,
                                              input logic [4:0]      wrd,
                                              input logic [XLEN-1:0] wdata);
    if (!en || idx == 5'd0)     resolve = '0;
    else if (wv && wrd == idx)  resolve = wdata;
    else                        resolve = rdata;
  endfunction

  assign rf_re1    = dec_rs1_en;
  assign rf_raddr1 = dec_rs1;
  assign rf_re2    = dec_rs2_en;
  assign rf_raddr2 = dec_rs2;

  // NOTE: every signal assigned in always_comb gets a default at the top so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    clr_mask = '0;
    if (wb_valid) clr_mask = onehot(wb_rd);
    clr_mask[0] = 1'b0;

    // A register retiring this cycle no longer blocks, since its value is
    // available through the writeback bypass.
    pend_eff = pending_q & ~clr_mask;

    hazard = (dec_rs1_en && dec_rs1 != 5'd0 && pend_eff[dec_rs1]) ||
             (dec_rs2_en && dec_rs2 != 5'd0 && pend_eff[dec_rs2]) ||
             (dec_rd_we  && dec_rd  != 5'd0 && pend_eff[dec_rd]);

    dec_ready = !flush && (!ex_valid_q || ex_ready) && !hazard;
    accept    = dec_valid && dec_ready;

    set_mask = '0;
    if (accept && dec_rd_we && dec_rd != 5'd0) set_mask = onehot(dec_rd);

    // A killed slot never writes back, so its pending bit is dropped here.
    // If execute takes the slot in the same cycle it is consumed, not killed.
    kill_mask = '0;
    if (flush && ex_valid_q && !ex_ready && ex_rd_we_q && ex_rd_q != 5'd0)
      kill_mask = onehot(ex_rd_q);

    // Set is applied last so it wins over a same-index clear.
    pending_d    = (pending_q & ~clr_mask & ~kill_mask) | set_mask;
    pending_d[0] = 1'b0;

    op1 = resolve(dec_rs1_en, dec_rs1, rf_rdata1, wb_valid, wb_rd, wb_data);
    op2 = resolve(dec_rs2_en, dec_rs2, rf_rdata2, wb_valid, wb_rd, wb_data);
  end

  // Output slot next state: load on accept, drop valid when consumed or
  // flushed, otherwise hold everything.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op1_d   = ex_op1_q;
    ex_op2_d   = ex_op2_q;
    ex_rd_d    = ex_rd_q;
    ex_rd_we_d = ex_rd_we_q;
    ex_pc_d    = ex_pc_q;
    ex_ctrl_d  = ex_ctrl_q;
    if (accept) begin
      ex_valid_d = 1'b1;
      ex_op1_d   = op1;
      ex_op2_d   = op2;
      ex_rd_d    = dec_rd;
      ex_rd_we_d = dec_rd_we;
      ex_pc_d    = dec_pc;
      ex_ctrl_d  = dec_ctrl;
    end else if (ex_ready || flush) begin
      ex_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (dec_valid && !dec_ready && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      ex_valid_q  <= 1'b0;
      ex_op1_q    <= '0;
      ex_op2_q    <= '0;
      ex_rd_q     <= '0;
      ex_rd_we_q  <= 1'b0;
      ex_pc_q     <= '0;
      ex_ctrl_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pending_q   <= pending_d;
      ex_valid_q  <= ex_valid_d;
      ex_op1_q    <= ex_op1_d;
      ex_op2_q    <= ex_op2_d;
      ex_rd_q     <= ex_rd_d;
      ex_rd_we_q  <= ex_rd_we_d;
      ex_pc_q     <= ex_pc_d;
      ex_ctrl_q   <= ex_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_op1    = ex_op1_q;
  assign ex_op2    = ex_op2_q;
  assign ex_rd     = ex_rd_q;
  assign ex_rd_we  = ex_rd_we_q;
  assign ex_pc     = ex_pc_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_issue_stage
//   Self-checking bench for issue_stage. Acts as decode, register file,
//   writeback and execute. Every accepted instruction pushes its expected
//   output slot contents onto a scoreboard queue; a monitor pops and compares
//   when execute consumes the slot, and discards entries killed by flush.
// -----------------------------------------------------------------------------
module tb_issue_stage;

  localparam int XLEN   = 32;
  localparam int PC_W   = 32;
  localparam int CTRL_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              dec_valid, dec_ready;
  logic [4:0]        dec_rs1, dec_rs2, dec_rd;
  logic              dec_rs1_en, dec_rs2_en, dec_rd_we;
  logic [PC_W-1:0]   dec_pc;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              rf_re1, rf_re2;
  logic [4:0]        rf_raddr1, rf_raddr2;
  logic [XLEN-1:0]   rf_rdata1, rf_rdata2;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              flush;
  logic              ex_valid, ex_ready;
  logic [XLEN-1:0]   ex_op1, ex_op2;
  logic [4:0]        ex_rd;
  logic              ex_rd_we;
  logic [PC_W-1:0]   ex_pc;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       stall_cnt;

  issue_stage #(.XLEN(XLEN), .PC_W(PC_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs1_en(dec_rs1_en),
    .dec_rs2(dec_rs2), .dec_rs2_en(dec_rs2_en),
    .dec_rd(dec_rd), .dec_rd_we(dec_rd_we),
    .dec_pc(dec_pc), .dec_ctrl(dec_ctrl),
    .rf_re1(rf_re1), .rf_raddr1(rf_raddr1), .rf_rdata1(rf_rdata1),
    .rf_re2(rf_re2), .rf_raddr2(rf_raddr2), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .ex_pc(ex_pc), .ex_ctrl(ex_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [4:0]        rd;
    logic              rd_we;
    logic [PC_W-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;

  typedef struct {
    logic [4:0]      rs1;
    logic            rs1_en;
    logic [4:0]      rs2;
    logic            rs2_en;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            wv;
    logic [4:0]      wrd;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] exp_op1;
    logic [XLEN-1:0] exp_op2;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_stall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_dec(input logic v, input logic [4:0] rs1, input logic e1,
                         input logic [4:0] rs2, input logic e2,
                         input logic [4:0] rd, input logic we,
                         input logic [PC_W-1:0] pc, input logic [CTRL_W-1:0] ctrl);
    dec_valid = v; dec_rs1 = rs1; dec_rs1_en = e1; dec_rs2 = rs2; dec_rs2_en = e2;
    dec_rd = rd; dec_rd_we = we; dec_pc = pc; dec_ctrl = ctrl;
  endtask

  // One decode cycle: check dec_ready against the expectation and, if the
  // instruction is expected to be accepted, push its expected slot contents.
  task automatic cyc(input logic exp_rdy, input logic [XLEN-1:0] op1, input logic [XLEN-1:0] op2);
    exp_t e;
    @(negedge clk);
    check("dec_ready", dec_ready, exp_rdy);
    if (dec_valid && !exp_rdy) exp_stall++;
    if (dec_valid && exp_rdy) begin
      e.op1 = op1; e.op2 = op2; e.rd = dec_rd; e.rd_we = dec_rd_we;
      e.pc = dec_pc; e.ctrl = dec_ctrl;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic wb(input logic [4:0] rd);
    dec_valid = 1'b0; wb_valid = 1'b1; wb_rd = rd; wb_data = 32'h0;
    step();
    wb_valid = 1'b0;
  endtask

  // Monitor: compare when execute consumes the slot, discard when killed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ex_valid && (ex_ready || flush)) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_underflow: got slot pc %0h expected no slot", ex_pc);
        end else begin
          e = sb.pop_front();
          if (ex_ready) begin
            check("ex_op1",   ex_op1,   e.op1);
            check("ex_op2",   ex_op2,   e.op2);
            check("ex_rd",    ex_rd,    e.rd);
            check("ex_rd_we", ex_rd_we, e.rd_we);
            check("ex_pc",    ex_pc,    e.pc);
            check("ex_ctrl",  ex_ctrl,  e.ctrl);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs[8];

  initial begin
    vecs[0] = '{5'd3,  1'b1, 5'd4,  1'b1, 32'h11,   32'h22,       1'b0, 5'd0,  32'h0,    32'h11,   32'h22};
    vecs[1] = '{5'd0,  1'b1, 5'd0,  1'b1, 32'hAAAA, 32'hBBBB,     1'b0, 5'd0,  32'h0,    32'h0,    32'h0};
    vecs[2] = '{5'd5,  1'b0, 5'd6,  1'b1, 32'h1,    32'h2,        1'b0, 5'd0,  32'h0,    32'h0,    32'h2};
    vecs[3] = '{5'd7,  1'b1, 5'd8,  1'b1, 32'h1,    32'h2,        1'b1, 5'd7,  32'h77,   32'h77,   32'h2};
    vecs[4] = '{5'd9,  1'b1, 5'd9,  1'b1, 32'h1,    32'h2,        1'b1, 5'd9,  32'h99,   32'h99,   32'h99};
    vecs[5] = '{5'd10, 1'b1, 5'd11, 1'b0, 32'h5A5A, 32'h2,        1'b1, 5'd12, 32'hCC,   32'h5A5A, 32'h0};
    vecs[6] = '{5'd0,  1'b1, 5'd31, 1'b1, 32'h1,    32'hFFFFFFFF, 1'b1, 5'd0,  32'h5,    32'h0,    32'hFFFFFFFF};
    vecs[7] = '{5'd30, 1'b1, 5'd31, 1'b1, 32'h3030, 32'h1,        1'b1, 5'd31, 32'hDEAD, 32'h3030, 32'hDEAD};

    rst = 1'b1;
    set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0, '0);
    rf_rdata1 = '0; rf_rdata2 = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0; ex_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex_valid",  ex_valid,      1'b0);
    check("rst_ex_op1",    ex_op1,        32'h0);
    check("rst_ex_pc",     ex_pc,         32'h0);
    check("rst_stall_cnt", stall_cnt,     32'h0);
    check("rst_pending",   dut.pending_q, 32'h0);
    rst = 1'b0;
    step();

    // addi x1, x0, imm
    set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 32'h100, 16'h0001);
    cyc(1'b1, 32'h0, 32'h0);
    check("t1_ex_valid", ex_valid,      1'b1);
    check("t1_pending",  dut.pending_q, 32'h2);

    // RAW: add x2, x1, x1 stalls until x1 writes back, then takes the bypass
    set_dec(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 32'h104, 16'h0002);
    rf_rdata1 = 32'hBAD0; rf_rdata2 = 32'hBAD0;
    cyc(1'b0, '0, '0);
    cyc(1'b0, '0, '0);
    check("t2_stall_cnt", stall_cnt, exp_stall);
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h1234;
    cyc(1'b1, 32'h1234, 32'h1234);
    wb_valid = 1'b0; dec_valid = 1'b0;
    check("t2_pending",   dut.pending_q, 32'h4);
    check("t2_stall_cnt", stall_cnt, 32'd2);
    wb(5'd2);
    check("t2_pending_clr", dut.pending_q, 32'h0);

    // Back-pressure: slot held for three cycles while execute is not ready
    ex_ready = 1'b0;
    set_dec(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h200, 16'h000A);
    rf_rdata1 = 32'h33;
    cyc(1'b1, 32'h33, 32'h0);
    set_dec(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h204, 16'h000B);
    rf_rdata1 = 32'h44;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, '0);
      check("t3_hold_valid", ex_valid, 1'b1);
      check("t3_hold_pc",    ex_pc,    32'h200);
      check("t3_hold_op1",   ex_op1,   32'h33);
      check("t3_hold_ctrl",  ex_ctrl,  16'h000A);
    end
    ex_ready = 1'b1;
    cyc(1'b1, 32'h44, 32'h0);
    check("t3_stall_cnt", stall_cnt, exp_stall);

    // Operand resolution table, back-to-back issue with no hazards
    for (int i = 0; i < 8; i++) begin
      set_dec(1'b1, vecs[i].rs1, vecs[i].rs1_en, vecs[i].rs2, vecs[i].rs2_en,
              5'd0, 1'b0, 32'h1000 + 32'(i * 4), 16'(i));
      rf_rdata1 = vecs[i].rdata1; rf_rdata2 = vecs[i].rdata2;
      wb_valid = vecs[i].wv; wb_rd = vecs[i].wrd; wb_data = vecs[i].wdata;
      #1;
      check("tab_raddr1", rf_raddr1, vecs[i].rs1);
      check("tab_re2",    rf_re2,    vecs[i].rs2_en);
      cyc(1'b1, vecs[i].exp_op1, vecs[i].exp_op2);
    end
    dec_valid = 1'b0; wb_valid = 1'b0;
    check("tab_pending", dut.pending_q, 32'h0);

    // WAW: second writer of x5 stalls; writeback and re-issue same cycle
    set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 32'h300, 16'h0005);
    cyc(1'b1, '0, '0);
    set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 32'h304, 16'h0006);
    cyc(1'b0, '0, '0);
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
    cyc(1'b1, '0, '0);
    wb_valid = 1'b0; dec_valid = 1'b0;
    check("t4_pending", dut.pending_q, 32'h20);
    wb(5'd5);
    check("t4_pending_clr", dut.pending_q, 32'h0);

    // Flush kills slot x7 while the older x3 stays pending
    set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 32'h400, 16'h0003);
    cyc(1'b1, '0, '0);
    set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 32'h404, 16'h0007);
    cyc(1'b1, '0, '0);
    ex_ready = 1'b0; flush = 1'b1;
    set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h408, 16'h0009);
    cyc(1'b0, '0, '0);
    flush = 1'b0; dec_valid = 1'b0;
    check("t5_ex_valid", ex_valid,      1'b0);
    check("t5_pending",  dut.pending_q, 32'h8);

    // Flush together with ex_ready: slot consumed, pending bit kept
    ex_ready = 1'b1;
    set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 32'h40C, 16'h0008);
    cyc(1'b1, '0, '0);
    dec_valid = 1'b0; flush = 1'b1;
    cyc(1'b0, '0, '0);
    flush = 1'b0;
    check("t5b_pending", dut.pending_q, 32'h108);
    wb(5'd3);
    wb(5'd8);
    check("t5b_pending_clr", dut.pending_q, 32'h0);
    check("t5_stall_cnt", stall_cnt, exp_stall);

    // Asynchronous reset in the middle of a stall
    ex_ready = 1'b0;
    set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 32'h500, 16'h0010);
    cyc(1'b1, '0, '0);
    set_dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 32'h504, 16'h0011);
    cyc(1'b0, '0, '0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_ex_valid",  ex_valid,      1'b0);
    check("t6_pending",   dut.pending_q, 32'h0);
    check("t6_stall_cnt", stall_cnt,     32'h0);
    dec_valid = 1'b0;
    #1;
    rst = 1'b0;
    sb.delete();
    exp_stall = 0;
    step();
    check("t6_post_valid", ex_valid,  1'b0);
    check("t6_post_stall", stall_cnt, 32'h0);

    step();
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
